// File: rtl/comm_master_pkt.sv
// Queued multi-byte command transmitter: buffers BYTES-wide commands in a
// DEPTH-entry FIFO and serialises each one to UART_tx via trmt/tx_data/tx_done.
module comm_master_pkt #(
    parameter int unsigned BYTES     = 2,
    parameter int unsigned DEPTH     = 4,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*BYTES-1:0]       cmd,
    input  logic                     snd_cmd,
    output logic                     cmd_rdy,
    output logic                     trmt,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     cmd_cmplt,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BYTES - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t state, state_nxt;

    logic [8*BYTES-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic [8*BYTES-1:0] head, head_ord, cmd_reg, cmd_shift;
    logic [CW-1:0]      byte_cnt;
    logic               full, push, load, advance, finish;

    assign full    = (count == FULL_CNT);
    assign push    = snd_cmd && !full;
    assign cmd_rdy = !full;
    assign pending = count;
    assign head    = mem[rd_ptr];

    // cmd_reg holds the command pre-ordered so the next byte is always the
    // low byte; shifting on each advance replaces a byte_cnt-indexed mux.
    for (genvar g = 0; g < BYTES; g++) begin : g_ord
        assign head_ord[8*g +: 8] = MSB_FIRST ? head[8*(BYTES-1-g) +: 8]
                                              : head[8*g +: 8];
    end

    assign cmd_shift = cmd_reg >> 8;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        trmt      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (count != '0) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                trmt      = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (byte_cnt == LAST_BYTE) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance   = 1'b1;
                        state_nxt = SEND;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            cmd_reg   <= '0;
            byte_cnt  <= '0;
            tx_data   <= '0;
            cmd_cmplt <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            if (push && !load)      count <= count + 1'b1;
            else if (!push && load) count <= count - 1'b1;
            if (snd_cmd && full) ovf <= 1'b1;
            cmd_cmplt <= finish;
            if (load) begin
                cmd_reg  <= head_ord;
                tx_data  <= head_ord[7:0];
                byte_cnt <= '0;
            end else if (advance) begin
                cmd_reg  <= cmd_shift;
                tx_data  <= cmd_shift[7:0];
                byte_cnt <= byte_cnt + 1'b1;
            end
        end
    end

endmodule
